mbist_march_ctrl: RTL and testbench

March C- test sequencer for the MBIST datapath. It drives the RAM under test with address, write data and read strobes, and presents the registered expected word on `data_t` to the magnitude comparator. It then samples the comparator's `eq` result and accumulates pass/fail status. It sits between the BIST start/status interface and the RAM plus comparator pair.

---
 rtl/mbist_pkg.sv | 27 ++
 rtl/mbist_addr_gen.sv | 19 +
 rtl/mbist_march_ctrl.sv | 108 ++++++++++
 tb/tb_mbist_march_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// mbist_pkg: shared types and the March C- element table for the MBIST sequencer.
// The sequencer honours `MBIST_FAIL_LOG_EN` to enable fail counting and first-fail capture.
package mbist_pkg;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] BG0 = 8'h00;
  localparam logic [DATA_W-1:0] BG1 = 8'hFF;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_t;
  typedef struct packed {
    logic up;
    logic [1:0] n_ops;
    logic rd_en;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] wr_val;
  } elem_cfg_t;
  // Single-op elements are a lone write (rd_en=0) or a lone read (rd_en=1).
  function automatic elem_cfg_t elem_cfg(input march_elem_t e);
    case (e)
      M0: return '{1'b1, 2'd1, 1'b0, BG0, BG0};
      M1: return '{1'b1, 2'd2, 1'b1, BG0, BG1};
      M2: return '{1'b1, 2'd2, 1'b1, BG1, BG0};
      M3: return '{1'b0, 2'd2, 1'b1, BG0, BG1};
      M4: return '{1'b0, 2'd2, 1'b1, BG1, BG0};
      default: return '{1'b0, 2'd1, 1'b1, BG0, BG0};
    endcase
  endfunction
endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: up/down address counter with load, step and terminal-address flag.
module mbist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              step,
  input  logic              up,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  always_comb addr_d = load ? load_val : step ? (up ? addr_q + 1'b1 : addr_q - 1'b1) : addr_q;
  always_ff @(posedge clk) addr_q <= !rst_n ? '0 : addr_d;
  assign addr = addr_q;
  assign last = up ? &addr_q : ~|addr_q;
endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- sequencer driving RAM ops and accumulating comparator results.
// Define MBIST_FAIL_LOG_EN to implement fail_count and first_fail_addr; otherwise both read 0.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [DATA_W-1:0] data_t,
  output logic              cmp_valid,
  input  logic              eq,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [CNT_W-1:0]  fail_count,
  output logic [ADDR_W-1:0] first_fail_addr
);
  state_t state_q, state_d;
  march_elem_t elem_q, elem_d, elem_nxt;
  elem_cfg_t cfg, cfg_nxt;
  logic phase_q, phase_d, cmp_valid_q, cmp_valid_d, fail_q, fail_d;
  logic [DATA_W-1:0] data_t_q, data_t_d;
  logic [ADDR_W-1:0] addr, ag_load_val;
  logic addr_last, ag_load, ag_step, run, accept, rd_op, addr_done, elem_end, mis;
  assign cfg = elem_cfg(elem_q);
  assign elem_nxt = march_elem_t'(elem_q + 3'd1);
  assign cfg_nxt = elem_cfg(elem_nxt);
  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk(clk), .rst_n(rst_n), .load(ag_load), .load_val(ag_load_val),
    .step(ag_step), .up(cfg.up), .addr(addr), .last(addr_last)
  );
  always_comb begin
    run = state_q == RUN;
    accept = state_q == IDLE && start;
    rd_op = run && !phase_q && cfg.rd_en;
    addr_done = {1'b0, phase_q} + 2'd1 == cfg.n_ops;
    elem_end = run && addr_done && addr_last;
    ag_load = accept || (elem_end && elem_q != M5);
    ag_load_val = (accept || cfg_nxt.up) ? '0 : {ADDR_W{1'b1}};
    ag_step = run && addr_done && !addr_last;
    state_d = accept ? RUN : (elem_end && elem_q == M5) ? DRAIN : state_q == DRAIN ? DONE :
              state_q == DONE ? IDLE : state_q;
    elem_d = accept ? M0 : (elem_end && elem_q != M5) ? elem_nxt : elem_q;
    phase_d = run && !addr_done;
    cmp_valid_d = rd_op;
    data_t_d = rd_op ? cfg.rd_val : '0;
    mis = cmp_valid_q && !eq;
    fail_d = !accept && (fail_q || mis);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      elem_q <= M0;
      phase_q <= 1'b0;
      cmp_valid_q <= 1'b0;
      data_t_q <= '0;
      fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q <= elem_d;
      phase_q <= phase_d;
      cmp_valid_q <= cmp_valid_d;
      data_t_q <= data_t_d;
      fail_q <= fail_d;
    end
  end
  assign ram_re = rd_op;
  assign ram_we = run && !rd_op;
  assign ram_addr = run ? addr : '0;
  assign ram_wdata = ram_we ? cfg.wr_val : '0;
  assign data_t = data_t_q;
  assign cmp_valid = cmp_valid_q;
  assign busy = run || state_q == DRAIN;
  assign done = state_q == DONE;
  assign fail = fail_q;
`ifdef MBIST_FAIL_LOG_EN
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d, first_fail_addr_q, first_fail_addr_d;
  always_comb begin
    cmp_addr_d = addr;
    fail_count_d = accept ? '0 : fail_count_q + CNT_W'(mis && !(&fail_count_q));
    first_fail_addr_d = accept ? '0 : (mis && !fail_q) ? cmp_addr_q : first_fail_addr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_count_q <= '0;
      cmp_addr_q <= '0;
      first_fail_addr_q <= '0;
    end else begin
      fail_count_q <= fail_count_d;
      cmp_addr_q <= cmp_addr_d;
      first_fail_addr_q <= first_fail_addr_d;
    end
  end
  assign fail_count = fail_count_q;
  assign first_fail_addr = first_fail_addr_q;
`else
  assign fail_count = '0;
  assign first_fail_addr = '0;
`endif
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: directed and randomized-fault March C- runs against a behavioural RAM and op-list model.
module tb_mbist_march_ctrl;
  localparam int AW = 4;
  localparam int N = 1 << AW;
  localparam int OPS = 10 * N;
`ifdef MBIST_FAIL_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  always #5 clk = ~clk;
  logic [AW-1:0] ram_addr, ffa, ram_addr2, ffa2;
  logic [7:0] ram_wdata, data_t, ram_wdata2, data_t2, fc;
  logic [7:0] ramout = 8'h00;
  logic [1:0] fc2;
  logic ram_we, ram_re, cmp_valid, eq, busy, done, fail;
  logic ram_we2, ram_re2, cmp_valid2, eq2, busy2, done2, fail2;

  mbist_march_ctrl #(.ADDR_W(AW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re), .data_t(data_t), .cmp_valid(cmp_valid), .eq(eq),
    .busy(busy), .done(done), .fail(fail), .fail_count(fc), .first_fail_addr(ffa)
  );
  mbist_march_ctrl #(.ADDR_W(AW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
    .ram_we(ram_we2), .ram_re(ram_re2), .data_t(data_t2), .cmp_valid(cmp_valid2), .eq(eq2),
    .busy(busy2), .done(done2), .fail(fail2), .fail_count(fc2), .first_fail_addr(ffa2)
  );

  // RAM with optional stuck-at bits at one address; the second DUT sees a RAM stuck at 0xA5.
  logic [7:0] mem [N];
  int fault_addr = -1;
  logic [7:0] sa0 = 8'h00, sa1 = 8'h00;
  function automatic logic [7:0] rd_word(int a, logic [7:0] v);
    return (a == fault_addr) ? ((v & ~sa0) | sa1) : v;
  endfunction
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ramout <= rd_word(int'(ram_addr), mem[ram_addr]);
  end
  assign eq = data_t == ramout;
  assign eq2 = data_t2 == 8'hA5;

  int tests = 0, fails = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {bit re; bit we; int addr; int wd; int bg;} op_t;
  op_t ops[$];
  int exp_fails, exp_first, exp_reads;

  // Expand the March C- element list into a per-cycle op list and predict the mismatches.
  task automatic build_model();
    int rv[6] = '{-1, 0, 1, 0, 1, 0};
    int wv[6] = '{0, 1, 0, 1, 0, -1};
    bit up[6] = '{1, 1, 1, 0, 0, 0};
    logic [7:0] m [N];
    ops.delete();
    exp_fails = 0;
    exp_first = -1;
    exp_reads = 0;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++) begin
        int a = up[e] ? i : N - 1 - i;
        if (rv[e] >= 0) begin
          logic [7:0] bg = rv[e] != 0 ? 8'hFF : 8'h00;
          ops.push_back('{1'b1, 1'b0, a, 0, int'(bg)});
          exp_reads++;
          if (rd_word(a, m[a]) !== bg) begin
            exp_fails++;
            if (exp_first < 0) exp_first = a;
          end
        end
        if (wv[e] >= 0) begin
          m[a] = wv[e] != 0 ? 8'hFF : 8'h00;
          ops.push_back('{1'b0, 1'b1, a, int'(m[a]), 0});
        end
      end
  endtask

  task automatic run_march(string name, int p1, int p2, output int nv);
    nv = 0;
    build_model();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= OPS + 2; k++) begin
      op_t o, pr;
      @(negedge clk);
      start = (k == p1 || k == p2);
      o = k <= OPS ? ops[k-1] : '{1'b0, 1'b0, 0, 0, 0};
      pr = (k > 1 && k <= OPS + 1) ? ops[k-2] : '{1'b0, 1'b0, 0, 0, 0};
      chk({name, "_re"}, ram_re, o.re);
      chk({name, "_we"}, ram_we, o.we);
      chk({name, "_addr"}, ram_addr, o.addr);
      chk({name, "_wdata"}, ram_wdata, o.wd);
      chk({name, "_cmp_valid"}, cmp_valid, pr.re);
      if (pr.re) chk({name, "_data_t"}, data_t, pr.bg);
      chk({name, "_busy"}, busy, k <= OPS + 1);
      chk({name, "_done"}, done, k == OPS + 2);
      nv += int'(cmp_valid);
    end
    start = 1'b0;
    chk({name, "_ncmp"}, nv, exp_reads);
    chk({name, "_fail"}, fail, exp_fails > 0);
    chk({name, "_fail_count"}, fc, LOG ? (exp_fails > 255 ? 255 : exp_fails) : 0);
    chk({name, "_first_fail"}, ffa, (LOG && exp_first >= 0) ? exp_first : 0);
    @(negedge clk);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_done"}, done, 0);
    chk({name, "_hold_fail"}, fail, exp_fails > 0);
  endtask

  initial begin
    int nv;
    repeat (3) @(negedge clk);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_re", ram_re, 0);
    chk("rst_data_t", data_t, 0);
    chk("rst_cmp_valid", cmp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fail_count", fc, 0);
    chk("rst_first_fail", ffa, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    run_march("clean", 0, 0, nv);
    chk("clean_80_compares", nv, 5 * N);
    chk("sat_fail", fail2, 1);
    chk("sat_fail_count", fc2, LOG ? 3 : 0);
    chk("sat_first_fail", ffa2, 0);

    fault_addr = 5;
    sa1 = 8'h01;
    run_march("sa1_a5", 0, 0, nv);
    chk("sa1_a5_count3", fc, LOG ? 3 : 0);
    chk("sa1_a5_addr5", ffa, LOG ? 5 : 0);
    fault_addr = -1;
    sa1 = 8'h00;

    run_march("ignore_start", 40, OPS + 1, nv);

    build_model();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_re", ram_re, 0);
    chk("midrst_we", ram_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmp_valid", cmp_valid, 0);
    chk("midrst_done", done, 0);
    rst_n = 1'b1;
    for (int k = 0; k < OPS; k++) begin
      @(negedge clk);
      if (done || busy || ram_re || ram_we) begin
        chk("midrst_quiet", {done, busy, ram_re, ram_we}, 0);
        break;
      end
    end
    chk("midrst_still_idle", busy, 0);
    run_march("rerun", 0, 0, nv);

    for (int t = 0; t < 6; t++) begin
      fault_addr = $urandom_range(0, N - 1);
      sa0 = $urandom_range(0, 1) != 0 ? 8'($urandom) : 8'h00;
      sa1 = $urandom_range(0, 1) != 0 ? 8'($urandom) : 8'h00;
      run_march($sformatf("rand%0d", t), 0, 0, nv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
